dcp_noc2_sched: RTL and testbench

Scheduler for the DCP's single outgoing NOC2 buffer port. It shares that port between three requesters inside the decoupling pipeline: store ACKs, load ACKs and TLoad (64-bit DRAM load) requests. It allocates a transaction ID (MSHR ID) to each TLoad request from a free list, and releases that ID when the matching NOC3 response handshakes. It sits between the DCP pipeline stages and the `dcp_noc2buffer_*` interface.

---
 rtl/dcp_sched_pkg.sv | 45 ++++
 rtl/dcp_id_pool.sv | 54 +++++
 rtl/dcp_noc2_sched.sv | 128 ++++++++++++
 tb/tb_dcp_noc2_sched.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcp_sched_pkg.sv
// rtl/dcp_sched_pkg.sv - shared types and constants for the DCP NOC2 scheduler
package dcp_sched_pkg;

    // Message type codes mirror the DCP_NOC2_* defines of dcp.h.
    localparam int MSG_TYPE_WIDTH = 8;
    localparam logic [MSG_TYPE_WIDTH-1:0] DCP_NOC2_LOAD_REQ64 = 8'd19;
    localparam logic [MSG_TYPE_WIDTH-1:0] DCP_NOC2_LOAD_ACK   = 8'd24;
    localparam logic [MSG_TYPE_WIDTH-1:0] DCP_NOC2_STORE_ACK  = 8'd25;

    localparam logic [3:0] DCP_DRAM_FBITS = 4'b1010;

    // Message struct fields are sized for the widest supported parameters.
    localparam int DCP_MSHRID_W = 4;
    localparam int DCP_PADDR    = 40;
    localparam int DCP_DATA_W   = 64;

    typedef enum logic [1:0] {
        SRC_ST = 2'd0,
        SRC_LD = 2'd1,
        SRC_TL = 2'd2
    } src_e;

    typedef struct packed {
        logic [MSG_TYPE_WIDTH-1:0] msg_type;
        logic [DCP_MSHRID_W-1:0]   mshrid;
        logic [DCP_PADDR-1:0]      address;
        logic [DCP_DATA_W-1:0]     data;
        logic [3:0]                fbits;
    } noc2_msg_t;

    // Round-robin pick: first eligible source at or after ptr in ST->LD->TL order.
    function automatic src_e rr_pick(input logic [2:0] elig, input src_e ptr);
        logic [5:0] rot;
        logic [2:0] sum;
        logic [1:0] off;
        rot = {elig, elig} >> ptr;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else             off = 2'd2;
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= 3'd3) sum = sum - 3'd3;
        return src_e'(sum[1:0]);
    endfunction

endpackage

// File: rtl/dcp_id_pool.sv
// rtl/dcp_id_pool.sv - TLoad transaction-ID free list with find-first allocation
module dcp_id_pool
    import dcp_sched_pkg::*;
#(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alloc,
    input  logic            rsp_hsk,
    input  logic [ID_W-1:0] rsp_mshrid,
    output logic [ID_W-1:0] free_id,
    output logic            full,
    output logic [ID_W:0]   outstanding,
    output logic            err_free
);

    localparam int POOL = 1 << ID_W;

    logic [POOL-1:0] busy_q;
    logic [POOL-1:0] alloc_mask;
    logic [POOL-1:0] free_mask;
    logic            rsp_hit;

    always_comb begin
        free_id = '0;
        for (int i = POOL - 1; i >= 0; i--) begin
            if (!busy_q[ID_W'(i)]) free_id = ID_W'(i);
        end
    end

    assign full       = (outstanding == (ID_W + 1)'(POOL));
    assign rsp_hit    = rsp_hsk && busy_q[rsp_mshrid];
    assign alloc_mask = alloc ? (POOL'(1) << free_id) : '0;
    assign free_mask  = rsp_hit ? (POOL'(1) << rsp_mshrid) : '0;

    // Allocation uses the pre-free bitmap; a same-cycle free lands next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            outstanding <= '0;
            err_free    <= 1'b0;
        end else begin
            busy_q <= (busy_q | alloc_mask) & ~free_mask;
            case ({alloc, rsp_hit})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (rsp_hsk && !busy_q[rsp_mshrid]) err_free <= 1'b1;
        end
    end

endmodule

// File: rtl/dcp_noc2_sched.sv
// rtl/dcp_noc2_sched.sv - round-robin scheduler for the DCP outgoing NOC2 port
module dcp_noc2_sched
    import dcp_sched_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      st_val,
    output logic                      st_rdy,
    input  logic [ID_W-1:0]           st_mshrid,
    input  logic [3:0]                st_fbits,
    input  logic                      ld_val,
    output logic                      ld_rdy,
    input  logic [ID_W-1:0]           ld_mshrid,
    input  logic [DATA_W-1:0]         ld_data,
    input  logic [3:0]                ld_fbits,
    input  logic                      tl_val,
    output logic                      tl_rdy,
    input  logic [ADDR_W-1:0]         tl_addr,
    output logic [ID_W-1:0]           tl_id,
    output logic                      noc2_val,
    input  logic                      noc2_rdy,
    output logic [MSG_TYPE_WIDTH-1:0] noc2_type,
    output logic [ID_W-1:0]           noc2_mshrid,
    output logic [ADDR_W-1:0]         noc2_address,
    output logic [DATA_W-1:0]         noc2_data,
    output logic [3:0]                noc2_fbits,
    input  logic                      rsp_hsk,
    input  logic [ID_W-1:0]           rsp_mshrid,
    output logic [ID_W:0]             outstanding,
    output logic                      err_free
);

    src_e       ptr_q;
    src_e       ptr_d;
    src_e       sel;
    logic [2:0] elig;
    logic       slot_avail;
    logic       any_grant;
    logic       pool_full;
    logic       val_q;
    noc2_msg_t  msg_q;
    noc2_msg_t  msg_d;

    dcp_id_pool #(.ID_W(ID_W)) u_id_pool (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc       (tl_rdy),
        .rsp_hsk     (rsp_hsk),
        .rsp_mshrid  (rsp_mshrid),
        .free_id     (tl_id),
        .full        (pool_full),
        .outstanding (outstanding),
        .err_free    (err_free)
    );

    assign slot_avail = !val_q || noc2_rdy;
    assign elig       = {tl_val && !pool_full, ld_val, st_val};
    assign sel        = rr_pick(elig, ptr_q);
    assign any_grant  = slot_avail && (|elig);

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= SRC_ST;
        else        ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_grant) begin
            case (sel)
                SRC_ST:  ptr_d = SRC_LD;
                SRC_LD:  ptr_d = SRC_TL;
                default: ptr_d = SRC_ST;
            endcase
        end
    end

    always_comb begin
        st_rdy = any_grant && (sel == SRC_ST);
        ld_rdy = any_grant && (sel == SRC_LD);
        tl_rdy = any_grant && (sel == SRC_TL);
    end

    always_comb begin
        msg_d = '0;
        case (sel)
            SRC_ST: begin
                msg_d.msg_type = DCP_NOC2_STORE_ACK;
                msg_d.mshrid   = DCP_MSHRID_W'(st_mshrid);
                msg_d.fbits    = st_fbits;
            end
            SRC_LD: begin
                msg_d.msg_type = DCP_NOC2_LOAD_ACK;
                msg_d.mshrid   = DCP_MSHRID_W'(ld_mshrid);
                msg_d.data     = DCP_DATA_W'(ld_data);
                msg_d.fbits    = ld_fbits;
            end
            default: begin
                msg_d.msg_type = DCP_NOC2_LOAD_REQ64;
                msg_d.mshrid   = DCP_MSHRID_W'(tl_id);
                msg_d.address  = DCP_PADDR'(tl_addr);
                msg_d.fbits    = DCP_DRAM_FBITS;
            end
        endcase
    end

    // Fields only change on a grant, so a stalled message stays stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q <= 1'b0;
            msg_q <= '0;
        end else if (slot_avail) begin
            val_q <= any_grant;
            if (any_grant) msg_q <= msg_d;
        end
    end

    assign noc2_val     = val_q;
    assign noc2_type    = msg_q.msg_type;
    assign noc2_mshrid  = msg_q.mshrid[ID_W-1:0];
    assign noc2_address = msg_q.address[ADDR_W-1:0];
    assign noc2_data    = msg_q.data[DATA_W-1:0];
    assign noc2_fbits   = msg_q.fbits;

endmodule

// File: tb/tb_dcp_noc2_sched.sv
// tb/tb_dcp_noc2_sched.sv - vector table plus message scoreboard for dcp_noc2_sched
module tb_dcp_noc2_sched;
    import dcp_sched_pkg::*;

    localparam int ID_W   = 2;
    localparam int ADDR_W = 40;
    localparam int DATA_W = 64;

    logic                      clk;
    logic                      rst_n;
    logic                      st_val, ld_val, tl_val;
    logic                      st_rdy, ld_rdy, tl_rdy;
    logic [ID_W-1:0]           st_mshrid, ld_mshrid, tl_id;
    logic [3:0]                st_fbits, ld_fbits;
    logic [DATA_W-1:0]         ld_data;
    logic [ADDR_W-1:0]         tl_addr;
    logic                      noc2_val, noc2_rdy;
    logic [MSG_TYPE_WIDTH-1:0] noc2_type;
    logic [ID_W-1:0]           noc2_mshrid;
    logic [ADDR_W-1:0]         noc2_address;
    logic [DATA_W-1:0]         noc2_data;
    logic [3:0]                noc2_fbits;
    logic                      rsp_hsk;
    logic [ID_W-1:0]           rsp_mshrid;
    logic [ID_W:0]             outstanding;
    logic                      err_free;

    dcp_noc2_sched #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_val       (st_val),
        .st_rdy       (st_rdy),
        .st_mshrid    (st_mshrid),
        .st_fbits     (st_fbits),
        .ld_val       (ld_val),
        .ld_rdy       (ld_rdy),
        .ld_mshrid    (ld_mshrid),
        .ld_data      (ld_data),
        .ld_fbits     (ld_fbits),
        .tl_val       (tl_val),
        .tl_rdy       (tl_rdy),
        .tl_addr      (tl_addr),
        .tl_id        (tl_id),
        .noc2_val     (noc2_val),
        .noc2_rdy     (noc2_rdy),
        .noc2_type    (noc2_type),
        .noc2_mshrid  (noc2_mshrid),
        .noc2_address (noc2_address),
        .noc2_data    (noc2_data),
        .noc2_fbits   (noc2_fbits),
        .rsp_hsk      (rsp_hsk),
        .rsp_mshrid   (rsp_mshrid),
        .outstanding  (outstanding),
        .err_free     (err_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       st;
        logic       ld;
        logic       tl;
        logic       rdy;
        logic       hsk;
        logic [1:0] rid;
        logic [2:0] gnt;
        logic [1:0] tid;
        int         out;
        logic       err;
    } vec_t;

    vec_t      vecs[$];
    noc2_msg_t sb[$];
    noc2_msg_t e;
    logic      m_val;
    int        checks;
    int        failures;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic st, input logic ld, input logic tl,
                       input logic rdy, input logic hsk, input logic [1:0] rid,
                       input logic [2:0] gnt, input logic [1:0] tid, input int out,
                       input logic err);
        vec_t v;
        v.rst = rst; v.st = st; v.ld = ld; v.tl = tl; v.rdy = rdy; v.hsk = hsk;
        v.rid = rid; v.gnt = gnt; v.tid = tid; v.out = out; v.err = err;
        vecs.push_back(v);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_val    = 1'b0;

        //  rst st ld tl rdy hsk rid  gnt   tid out err
        // ST/LD alternation
        add(0, 1, 1, 0, 1, 0, 0, 3'b001, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 3'b010, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 3'b001, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 3'b010, 0, 0, 0);
        // pool exhaustion interleaved with store ACKs
        add(0, 1, 0, 1, 1, 0, 0, 3'b100, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 0, 3'b001, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 0, 3'b100, 1, 2, 0);
        add(0, 1, 0, 1, 1, 0, 0, 3'b001, 0, 2, 0);
        add(0, 1, 0, 1, 1, 0, 0, 3'b100, 2, 3, 0);
        add(0, 1, 0, 1, 1, 0, 0, 3'b001, 0, 3, 0);
        add(0, 1, 0, 1, 1, 0, 0, 3'b100, 3, 4, 0);
        add(0, 1, 0, 1, 1, 0, 0, 3'b001, 0, 4, 0);
        add(0, 1, 0, 1, 1, 0, 0, 3'b001, 0, 4, 0);
        add(0, 0, 0, 1, 1, 1, 2, 3'b000, 0, 3, 0);
        add(0, 0, 0, 1, 1, 0, 0, 3'b100, 2, 4, 0);
        // same-cycle allocate/free with {0,1} allocated
        add(0, 0, 0, 0, 1, 1, 3, 3'b000, 0, 3, 0);
        add(0, 0, 0, 0, 1, 1, 2, 3'b000, 0, 2, 0);
        add(0, 0, 0, 1, 1, 1, 0, 3'b100, 2, 2, 0);
        add(0, 0, 0, 1, 1, 0, 0, 3'b100, 0, 3, 0);
        // spurious free of ID 3
        add(0, 0, 0, 0, 1, 1, 3, 3'b000, 0, 3, 1);
        add(0, 0, 0, 0, 1, 0, 0, 3'b000, 0, 3, 1);
        // backpressure on a held TLoad
        add(0, 0, 0, 1, 1, 0, 0, 3'b100, 3, 4, 1);
        for (int k = 0; k < 5; k++) add(0, 1, 1, 1, 0, 0, 0, 3'b000, 0, 4, 1);
        add(0, 1, 1, 1, 1, 0, 0, 3'b001, 0, 4, 1);
        add(0, 0, 0, 0, 1, 0, 0, 3'b000, 0, 4, 1);
        // reset mid-operation with 3 IDs allocated and a message held
        add(0, 1, 0, 0, 1, 1, 3, 3'b001, 0, 3, 1);
        add(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 3'b100, 0, 1, 0);

        rst_n = 1'b0;
        st_val = 0; ld_val = 0; tl_val = 0; noc2_rdy = 0; rsp_hsk = 0;
        st_mshrid = '0; ld_mshrid = '0; st_fbits = '0; ld_fbits = '0;
        ld_data = '0; tl_addr = '0; rsp_mshrid = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_val", 64'(noc2_val), 64'd0);
        chk("reset_fields", 64'({noc2_type, noc2_mshrid, noc2_fbits}), 64'd0);
        chk("reset_addr_data", 64'(noc2_address) | noc2_data, 64'd0);
        chk("reset_outstanding", 64'(outstanding), 64'd0);
        chk("reset_err_free", 64'(err_free), 64'd0);

        foreach (vecs[n]) begin
            @(negedge clk);
            rst_n      = ~vecs[n].rst;
            st_val     = vecs[n].st;
            ld_val     = vecs[n].ld;
            tl_val     = vecs[n].tl;
            noc2_rdy   = vecs[n].rdy;
            rsp_hsk    = vecs[n].hsk;
            rsp_mshrid = vecs[n].rid;
            st_mshrid  = ID_W'($urandom);
            ld_mshrid  = ID_W'($urandom);
            st_fbits   = 4'($urandom);
            ld_fbits   = 4'($urandom);
            ld_data    = {$urandom, $urandom};
            tl_addr    = ADDR_W'({$urandom, $urandom});
            #1;
            chk($sformatf("grant[%0d]", n), 64'({tl_rdy, ld_rdy, st_rdy}), 64'(vecs[n].gnt));
            if (vecs[n].gnt[2]) chk($sformatf("tl_id[%0d]", n), 64'(tl_id), 64'(vecs[n].tid));

            if (vecs[n].rst) begin
                sb.delete();
                m_val = 1'b0;
            end else begin
                if (m_val && vecs[n].rdy) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                end
                if (vecs[n].gnt != 3'b000) begin
                    e = '0;
                    if (vecs[n].gnt[0]) begin
                        e.msg_type = DCP_NOC2_STORE_ACK;
                        e.mshrid   = DCP_MSHRID_W'(st_mshrid);
                        e.fbits    = st_fbits;
                    end else if (vecs[n].gnt[1]) begin
                        e.msg_type = DCP_NOC2_LOAD_ACK;
                        e.mshrid   = DCP_MSHRID_W'(ld_mshrid);
                        e.data     = ld_data;
                        e.fbits    = ld_fbits;
                    end else begin
                        e.msg_type = DCP_NOC2_LOAD_REQ64;
                        e.mshrid   = DCP_MSHRID_W'(vecs[n].tid);
                        e.address  = tl_addr;
                        e.fbits    = DCP_DRAM_FBITS;
                    end
                    sb.push_back(e);
                end
                m_val = (vecs[n].gnt != 3'b000) || (m_val && !vecs[n].rdy);
            end

            @(posedge clk);
            #1;
            chk($sformatf("outstanding[%0d]", n), 64'(outstanding), 64'(vecs[n].out));
            chk($sformatf("err_free[%0d]", n), 64'(err_free), 64'(vecs[n].err));
            chk($sformatf("noc2_val[%0d]", n), 64'(noc2_val), 64'(m_val));
            if (m_val) begin
                if (sb.size() == 0) begin
                    chk($sformatf("sb_empty[%0d]", n), 64'd1, 64'd0);
                end else begin
                    chk($sformatf("type[%0d]", n), 64'(noc2_type), 64'(sb[0].msg_type));
                    chk($sformatf("mshrid[%0d]", n), 64'(noc2_mshrid), 64'(sb[0].mshrid[ID_W-1:0]));
                    chk($sformatf("address[%0d]", n), 64'(noc2_address), 64'(sb[0].address));
                    chk($sformatf("data[%0d]", n), noc2_data, sb[0].data);
                    chk($sformatf("fbits[%0d]", n), 64'(noc2_fbits), 64'(sb[0].fbits));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
